serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the frame bit counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  A/B/in_first/in_last/Borrow_in qualified this cycle.
REQ-005 in_first  input  1  first (LSB) bit of a frame.
REQ-006 in_last  input  1  last (MSB) bit of a frame.
REQ-007 A  input  1  minuend bit, LSB first.
REQ-008 B  input  1  subtrahend bit, LSB first.
REQ-009 Borrow_in  input  1  initial borrow; sampled only with in_valid & in_first.
REQ-010 out_valid  output  1  Diff is valid.
REQ-011 out_last  output  1  Diff is the MSB of the frame; Borrow_out and bit_count are valid.
REQ-012 Diff  output  1  difference bit.
REQ-013 Borrow_out  output  1  final borrow of the frame; 0 when out_last=0.
REQ-014 bit_count  output  CNT_W  number of bits in the frame, saturating; 0 when out_last=0.
REQ-015 seq_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-016 Arithmetic per accepted bit: Diff = A ^ B ^ b, borrow_next = (~A & B) | (~(A ^ B) & b), where b = Borrow_in if in_first else the internal borrow register.
REQ-017 FSM states: IDLE and ACTIVE; reset state IDLE.
REQ-018 IDLE + in_valid & in_first & ~in_last -> ACTIVE; IDLE + in_valid & in_first & in_last -> IDLE (single-bit frame, fully processed).
REQ-019 IDLE + in_valid & ~in_first -> IDLE; bit dropped, no out_valid, seq_err pulses the following cycle.
REQ-020 ACTIVE + in_valid & in_last -> IDLE; ACTIVE + in_valid & ~in_first & ~in_last -> ACTIVE.
REQ-021 ACTIVE + in_valid & in_first: current frame abandoned, seq_err pulses, new frame starts (borrow reloaded from Borrow_in, counter reset to 1); if in_last is also high, the single-bit frame completes.
REQ-022 Cycles with in_valid=0 are gaps: borrow register, counter, and FSM state hold; no output is produced for that slot.
REQ-023 Stage 1 registers Diff, borrow_next, last flag, and count; stage 2 registers the outputs; latency is exactly 2 cycles from the sampling edge to output visibility, throughput 1 bit/cycle.
REQ-024 The bit counter loads 1 on in_first and increments per accepted bit; it saturates at 2^CNT_W-1 without wrapping.
REQ-025 out_valid, out_last, Diff, Borrow_out, and bit_count form one aligned output beat; gaps propagate as out_valid=0 beats.
REQ-026 An abandoned frame never asserts out_last; its already-issued bits remain valid with out_last=0.

Reset
REQ-027 When rst_n=0 at a rising edge, the FSM goes to IDLE and the borrow register, counter, and both pipeline stages clear to 0.
REQ-028 All outputs are 0 from the first edge sampling rst_n=0 until the first valid beat after release.
REQ-029 Reset mid-frame discards all in-flight bits; no out_valid or seq_err is produced from pre-reset inputs.
REQ-030 After release, the first accepted bit must carry in_first; otherwise REQ-019 applies.

Verification
REQ-031 5-3, 4-bit frame, A=1,0,1,0, B=1,1,0,0, Borrow_in=0 -> Diff=0,1,0,0 on 4 consecutive beats from cycle+2; last beat has out_last=1, Borrow_out=0, bit_count=4.
REQ-032 3-5, 4-bit frame, A=1,1,0,0, B=1,0,1,0 -> Diff=0,1,1,1; final beat Borrow_out=1, bit_count=4.
REQ-033 Single-bit frame, A=0, B=0, Borrow_in=1, in_first=in_last=1 -> one beat with Diff=1, out_last=1, Borrow_out=1, bit_count=1.
REQ-034 Frame from REQ-031 with in_valid=0 for 2 cycles between bits 2 and 3 -> same Diff/Borrow_out values; two out_valid=0 beats inserted at the matching positions.
REQ-035 in_valid with in_first=0 in IDLE -> no out_valid; seq_err=1 for exactly one cycle. in_first mid-frame -> seq_err pulse; the old frame has no out_last; the new frame's result is correct.
REQ-036 rst_n=0 for 1 cycle after bit 2 of a 4-bit frame -> out_valid=0 thereafter until a new in_first frame; Borrow_out=0 and bit_count=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: frames arrive LSB first with first/last markers.
// Each accepted bit goes through two pipeline stages to a frame-aligned output beat.
module serial_subtractor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             A,
    input  logic             B,
    input  logic             Borrow_in,
    output logic             out_valid,
    output logic             out_last,
    output logic             Diff,
    output logic             Borrow_out,
    output logic [CNT_W-1:0] bit_count,
    output logic             seq_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               vld_p1;
    logic               diff_p1;
    logic               borrow_p1;
    logic               last_p1;
    logic [CNT_W-1:0]   cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic borrow_fn(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    logic               b_in;
    logic               diff_c;
    logic               bnext_c;
    logic               accept;
    logic               err_c;
    logic [CNT_W-1:0]   cnt_next;

    always_comb begin
        b_in     = in_first ? Borrow_in : borrow_q;
        diff_c   = A ^ B ^ b_in;
        bnext_c  = borrow_fn(A, B, b_in);
        // A bit is only usable when it starts a frame or continues an open one.
        accept   = in_valid & (in_first | (state == ACTIVE));
        err_c    = in_valid & (in_first ? (state == ACTIVE) : (state == IDLE));
        cnt_next = in_first ? CNT_W'(1) : sat_inc(cnt_q);
    end

    // Frame control and stage 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            seq_err   <= 1'b0;
            vld_p1    <= 1'b0;
            diff_p1   <= 1'b0;
            borrow_p1 <= 1'b0;
            last_p1   <= 1'b0;
            cnt_p1    <= '0;
        end else begin
            seq_err <= err_c;
            vld_p1  <= accept;
            last_p1 <= accept & in_last;
            if (accept) begin
                state     <= in_last ? IDLE : ACTIVE;
                borrow_q  <= bnext_c;
                cnt_q     <= cnt_next;
                diff_p1   <= diff_c;
                borrow_p1 <= bnext_c;
                cnt_p1    <= cnt_next;
            end
        end
    end

    // Stage 2: frame summary fields are only exposed on the closing beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            Diff       <= 1'b0;
            Borrow_out <= 1'b0;
            bit_count  <= '0;
        end else begin
            out_valid  <= vld_p1;
            out_last   <= last_p1;
            Diff       <= vld_p1 & diff_p1;
            Borrow_out <= last_p1 & borrow_p1;
            bit_count  <= last_p1 ? cnt_p1 : '0;
        end
    end

endmodule
